// File: rtl/scr1_vec_tcm.sv
// Vector TCM: LANE x 32-bit banks sharing one row index; 1-cycle registered response, accepts 1 access/cycle.
// Optional post-reset zero-fill sweep (req_ack held low meanwhile) under macro SCR1_VEC_TCM_INIT_EN.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef LANE
`define LANE 4
`endif

package scr1_vec_tcm_pkg;
   typedef enum logic [1:0] {
      SCR1_MEM_CMD_RD    = 2'b00,
      SCR1_MEM_CMD_WR    = 2'b01,
      SCR1_MEM_CMD_ERROR = 2'b11
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef logic [`LANE-1:0][31:0] type_vector;
endpackage

module scr1_vec_tcm
   import scr1_vec_tcm_pkg::*;
#(
   parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_VEC_TCM_BASE  = `SCR1_DMEM_AWIDTH'h00010000,
   parameter int unsigned                  SCR1_VEC_TCM_DEPTH = 1024
) (
   input  logic                          rst_n,
   input  logic                          clk,
   output logic                          req_ack,
   input  logic                          req,
   input  type_scr1_mem_cmd_e            cmd,
   input  type_scr1_mem_width_e          width,
   input  logic [`SCR1_DMEM_AWIDTH-1:0]  addr,
   input  type_vector                    wdata,
   output type_vector                    rdata,
   output type_scr1_mem_resp_e           resp
);
   localparam int unsigned AW        = `SCR1_DMEM_AWIDTH;
   localparam int unsigned LANES     = `LANE;
   localparam int unsigned LANE_W    = $clog2(LANES);
   localparam int unsigned ROW_W     = $clog2(SCR1_VEC_TCM_DEPTH);
   localparam logic [AW-1:0] MEM_BYTES = AW'(SCR1_VEC_TCM_DEPTH * LANES * 4);
   localparam logic [AW-1:0] LANE_MASK = AW'(LANES * 4 - 1) & ~AW'(3);

   logic [AW-1:0]    off;
   logic [ROW_W-1:0] row;
   logic [1:0]       bsel;
   logic [3:0]       be;
   logic             acc_err;
   logic             acc_vld;
   logic             wr_en;
   logic             rd_en;
   logic             init_wr;
   logic [ROW_W-1:0] init_row;

   type_scr1_mem_resp_e resp_q, resp_d;
   type_vector          rdata_q, rdata_d;
   logic [31:0]         mem_q [LANES][SCR1_VEC_TCM_DEPTH];

   always_comb begin
      off     = addr - SCR1_VEC_TCM_BASE;
      row     = ROW_W'(off >> (2 + LANE_W));
      bsel    = off[1:0];
      be      = 4'h0;
      acc_err = 1'b0;
      if (cmd != SCR1_MEM_CMD_RD && cmd != SCR1_MEM_CMD_WR) acc_err = 1'b1;
      case (width)
         SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << bsel;
         SCR1_MEM_WIDTH_HWORD: begin
            be = 4'b0011 << bsel;
            if (bsel[0]) acc_err = 1'b1;
         end
         SCR1_MEM_WIDTH_WORD: begin
            be = 4'hF;
            if (bsel != 2'b00) acc_err = 1'b1;
         end
         default: acc_err = 1'b1;
      endcase
      // Unsigned compare also rejects addresses below the window base
      if (off >= MEM_BYTES) acc_err = 1'b1;
      if (|(off & LANE_MASK)) acc_err = 1'b1;
   end

   assign acc_vld = req & req_ack;
   assign wr_en   = acc_vld & ~acc_err & (cmd == SCR1_MEM_CMD_WR);
   assign rd_en   = acc_vld & ~acc_err & (cmd == SCR1_MEM_CMD_RD);

`ifdef SCR1_VEC_TCM_INIT_EN
   typedef enum logic {ST_INIT, ST_RUN} state_e;
   state_e           state_q, state_d;
   logic [ROW_W-1:0] init_row_q, init_row_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_row_q <= '0;
      end else begin
         state_q    <= state_d;
         init_row_q <= init_row_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_row_d = init_row_q;
      if (state_q == ST_INIT) begin
         init_row_d = init_row_q + 1'b1;
         if (init_row_q == ROW_W'(SCR1_VEC_TCM_DEPTH - 1)) state_d = ST_RUN;
      end
   end

   always_comb begin
      req_ack = (state_q == ST_RUN);
      init_wr = (state_q == ST_INIT);
   end

   assign init_row = init_row_q;
`else
   assign req_ack  = 1'b1;
   assign init_wr  = 1'b0;
   assign init_row = '0;
`endif

   // Write commits on the acceptance edge, so a read accepted next cycle sees merged bytes
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         for (int b = 0; b < 4; b++) begin
            if (init_wr) begin
               mem_q[l][init_row][8*b +: 8] <= 8'h00;
            end else if (wr_en && be[b]) begin
               mem_q[l][row][8*b +: 8] <= wdata[l][8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      resp_d  = SCR1_MEM_RESP_NOTRDY;
      rdata_d = '0;
      if (acc_vld) begin
         resp_d = acc_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      end
      if (rd_en) begin
         for (int l = 0; l < LANES; l++) rdata_d[l] = mem_q[l][row];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q  <= SCR1_MEM_RESP_NOTRDY;
         rdata_q <= '0;
      end else begin
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

   assign resp  = resp_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_scr1_vec_tcm.sv
// Bench for scr1_vec_tcm: directed scenarios plus random traffic against a byte-addressed memory model.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef LANE
`define LANE 4
`endif

module tb_scr1_vec_tcm;
   import scr1_vec_tcm_pkg::*;

   localparam int LANES  = `LANE;
   localparam int DEPTH  = 64;
   localparam int ROWB   = LANES * 4;
   localparam int NBYTES = DEPTH * ROWB;
   localparam logic [`SCR1_DMEM_AWIDTH-1:0] BASE = `SCR1_DMEM_AWIDTH'h00010000;
`ifdef SCR1_VEC_TCM_INIT_EN
   localparam int INIT_CYC = DEPTH;
`else
   localparam int INIT_CYC = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req = 1'b0;
   logic req_ack;
   type_scr1_mem_cmd_e   cmd   = SCR1_MEM_CMD_RD;
   type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
   logic [`SCR1_DMEM_AWIDTH-1:0] addr = '0;
   type_vector wdata = '0;
   type_vector rdata;
   type_scr1_mem_resp_e resp;

   logic [7:0] mem_m [NBYTES];
   int n_chk  = 0;
   int n_pass = 0;

   scr1_vec_tcm #(
      .SCR1_VEC_TCM_BASE (BASE),
      .SCR1_VEC_TCM_DEPTH(DEPTH)
   ) dut (
      .rst_n  (rst_n),
      .clk    (clk),
      .req_ack(req_ack),
      .req    (req),
      .cmd    (cmd),
      .width  (width),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .resp   (resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic type_vector model_row(input int rb);
      type_vector v;
      for (int l = 0; l < LANES; l++)
         for (int b = 0; b < 4; b++)
            v[l][8*b +: 8] = mem_m[rb + 4*l + b];
      return v;
   endfunction

   function automatic type_vector fill_vec(input logic [31:0] w);
      type_vector v;
      for (int l = 0; l < LANES; l++) v[l] = w;
      return v;
   endfunction

   // One access; response is checked in the following cycle, leaving req low so a
   // subsequent call in the same timestep continues back-to-back
   task automatic do_acc(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                         input logic [`SCR1_DMEM_AWIDTH-1:0] a, input type_vector wd, input string tag);
      logic [`SCR1_DMEM_AWIDTH-1:0] off;
      int sz, bs, rb;
      bit err;
      type_vector exp_rd;
      type_scr1_mem_resp_e exp_resp;
      req = 1'b1; cmd = c; width = w; addr = a; wdata = wd;
      #1;
      chk({tag, "_ack"}, 256'(req_ack), 256'(1'b1));
      off = a - BASE;
      sz  = (w == SCR1_MEM_WIDTH_BYTE) ? 1 : (w == SCR1_MEM_WIDTH_HWORD) ? 2 :
            (w == SCR1_MEM_WIDTH_WORD) ? 4 : 0;
      err = (c != SCR1_MEM_CMD_RD && c != SCR1_MEM_CMD_WR) || (sz == 0) ||
            (off >= NBYTES) || ((off % ROWB) >= 4);
      if (!err && (off % sz) != 0) err = 1'b1;
      exp_rd   = '0;
      exp_resp = err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      if (!err) begin
         rb = int'(off / ROWB) * ROWB;
         bs = int'(off % 4);
         if (c == SCR1_MEM_CMD_WR) begin
            for (int l = 0; l < LANES; l++)
               for (int k = 0; k < sz; k++)
                  mem_m[rb + 4*l + bs + k] = wd[l][8*(bs+k) +: 8];
         end else begin
            exp_rd = model_row(rb);
         end
      end
      tick();
      req = 1'b0;
      chk({tag, "_resp"}, 256'(resp), 256'(exp_resp));
      chk({tag, "_rdata"}, 256'(rdata), 256'(exp_rd));
   endtask

   task automatic idle(input string tag);
      req = 1'b0;
      cmd = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      tick();
      chk({tag, "_resp"}, 256'(resp), 256'(SCR1_MEM_RESP_NOTRDY));
      chk({tag, "_rdata"}, 256'(rdata), 256'(0));
   endtask

   task automatic release_and_wait(input string tag);
      int cnt = 0;
      rst_n = 1'b1;
      while (req_ack !== 1'b1 && cnt < 4*DEPTH + 8) begin
         cnt++;
         tick();
      end
      chk(tag, 256'(cnt), 256'(INIT_CYC));
`ifdef SCR1_VEC_TCM_INIT_EN
      for (int k = 0; k < NBYTES; k++) mem_m[k] = 8'h00;
`endif
   endtask

   function automatic type_vector rand_vec();
      type_vector v;
      for (int l = 0; l < LANES; l++) v[l] = $urandom;
      return v;
   endfunction

   initial begin
      type_vector v;
      type_scr1_mem_cmd_e   c;
      type_scr1_mem_width_e w;
      logic [`SCR1_DMEM_AWIDTH-1:0] a;
      int r;

      for (int k = 0; k < NBYTES; k++) mem_m[k] = 8'h00;
      tick();
      tick();
      chk("rst_resp", 256'(resp), 256'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", 256'(rdata), 256'(0));
      release_and_wait("rst_release_wait");

      for (int row = 0; row < DEPTH; row++)
         do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + row*ROWB, rand_vec(), "prefill");

      // WORD write / read-back with per-lane pattern
      for (int l = 0; l < LANES; l++) v[l] = 32'hA000_0000 + l;
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE, v, "word_wr");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE, '0, "word_rd");
      chk("word_rd_lit", 256'(rdata), 256'(v));

      // BYTE merge, then a misaligned HWORD that must not disturb the row
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + ROWB, fill_vec(32'hFFFF_FFFF), "ff_wr");
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, BASE + ROWB + 2, fill_vec(32'h0055_0000), "byte_wr");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + ROWB, '0, "byte_rd");
      chk("byte_rd_lit", 256'(rdata), 256'(fill_vec(32'hFF55_FFFF)));
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, BASE + ROWB + 1, fill_vec(32'h1234_5678), "hw_mis");
      chk("hw_mis_lit", 256'(resp), 256'(SCR1_MEM_RESP_RDY_ER));
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + ROWB, '0, "hw_mis_rd");
      chk("hw_mis_rd_lit", 256'(rdata), 256'(fill_vec(32'hFF55_FFFF)));
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, BASE + ROWB + 2, fill_vec(32'hBEEF_0000), "hw_hi");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + ROWB, '0, "hw_hi_rd");
      chk("hw_hi_rd_lit", 256'(rdata), 256'(fill_vec(32'hBEEF_FFFF)));

      // Back-to-back write then reads of the same and next row
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 3*ROWB, fill_vec(32'h3333_CAFE), "b2b_wr");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 3*ROWB, '0, "b2b_rd3");
      chk("b2b_rd3_lit", 256'(rdata), 256'(fill_vec(32'h3333_CAFE)));
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 4*ROWB, '0, "b2b_rd4");
      idle("b2b_idle");

      // Error cases
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + NBYTES, '0, "err_top");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE - 4, '0, "err_below");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 4, '0, "err_lane");
      do_acc(SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, BASE, '0, "err_cmd");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, BASE, '0, "err_width");
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 2*ROWB + 2, fill_vec(32'h0), "err_wmis");
      chk("err_wmis_lit", 256'(resp), 256'(SCR1_MEM_RESP_RDY_ER));
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + (DEPTH-1)*ROWB, '0, "last_row");

      // Reset during the response cycle of a read
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 5*ROWB, '0, "pre_rst");
      rst_n = 1'b0;
      #1;
      chk("midrst_resp", 256'(resp), 256'(SCR1_MEM_RESP_NOTRDY));
      chk("midrst_rdata", 256'(rdata), 256'(0));
      tick();
      tick();
      release_and_wait("midrst_release_wait");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 5*ROWB, '0, "post_rst_rd5");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 9*ROWB, '0, "post_rst_rd9");
      do_acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 9*ROWB, fill_vec(32'h9999_0001), "post_rst_wr");
      do_acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 9*ROWB, '0, "post_rst_rd");
      chk("post_rst_rd_lit", 256'(rdata), 256'(fill_vec(32'h9999_0001)));

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            idle("rnd_idle");
         end else begin
            c = ($urandom_range(0, 19) == 0) ? SCR1_MEM_CMD_ERROR :
                ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
            r = $urandom_range(0, 15);
            w = (r < 5) ? SCR1_MEM_WIDTH_BYTE : (r < 10) ? SCR1_MEM_WIDTH_HWORD :
                (r < 15) ? SCR1_MEM_WIDTH_WORD : SCR1_MEM_WIDTH_ERROR;
            a = BASE + $urandom_range(0, DEPTH-1) * ROWB + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = a + 4 * $urandom_range(1, LANES-1);
            r = $urandom_range(0, 39);
            if (r == 0) a = BASE + NBYTES + $urandom_range(0, 255);
            if (r == 1) a = BASE - 1 - $urandom_range(0, 255);
            do_acc(c, w, a, rand_vec(), "rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scr1_vec_tcm.md
Name: scr1_vec_tcm

Overview:
- Vector tightly-coupled data memory.
- Sits directly downstream of the data memory router's PORT1 (vector window). It consumes the router's PORT1 req/cmd/width/addr/wdata and returns req_ack/rdata/resp.
- Storage is LANE 32-bit banks sharing one row index. Every accepted access reads or writes all lanes of one row.
- Response latency is one cycle. Back-to-back accesses are accepted at full throughput.

Parameters:
- SCR1_VEC_TCM_BASE, `SCR1_DMEM_AWIDTH'h00010000: byte base address of the memory window.
- SCR1_VEC_TCM_DEPTH, 1024: rows per bank. Must be a power of two, ≥2.
- LANE is taken from `LANE (defines.svh). Row stride = LANE*4 bytes.

Ports:
- rst_n  input  1  asynchronous active-low reset
- clk  input  1  clock; all state updates on posedge
- req_ack  output  1  request accepted this cycle when req & req_ack
- req  input  1  request valid
- cmd  input  type_scr1_mem_cmd_e  RD / WR / ERROR
- width  input  type_scr1_mem_width_e  BYTE / HWORD / WORD / ERROR
- addr  input  `SCR1_DMEM_AWIDTH  byte address
- wdata  input  type_vector  LANE x 32-bit write data
- rdata  output  type_vector  LANE x 32-bit read data
- resp  output  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
Reset and fixed outputs:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values: resp = SCR1_MEM_RESP_NOTRDY, rdata = '0, internal pending flag = 0. Memory contents are not reset unless SCR1_VEC_TCM_INIT_EN is defined.
- req_ack = 1 whenever not in the init sweep. It is combinational and does not depend on req.

Address decode (per request):
- off = addr - BASE.
- row = off >> (2 + log2(LANE)).
- lane_off = off[log2(LANE)+1:2].
- bsel = off[1:0].

Error conditions (any one gives RDY_ER):
- cmd == ERROR or width == ERROR.
- off >= DEPTH*LANE*4 (unsigned compare, so addresses below BASE also fail).
- lane_off != 0 (access not row-aligned).
- HWORD with bsel[0] = 1.
- WORD with bsel != 0.

Acceptance (cycle T, req & req_ack):
- Decode and error check are registered.
- Write without error: commit at posedge ending cycle T to all LANE banks at row. Per-lane byte enables:
  - BYTE: 1<<bsel.
  - HWORD: 2'b11<<bsel.
  - WORD: 4'hF.
  - wdata lane i goes to bank i, byte lanes taken in place (the core pre-positions the data).
- Read without error: all banks read at row. Data is valid in cycle T+1.
- Error: no memory access, no state change.

Response (cycle T+1):
- resp = RDY_OK or RDY_ER. resp = NOTRDY in any cycle not following an acceptance.
- On read OK: rdata lane i = full 32-bit word of bank i. Byte/halfword extraction is done by the core.
- On write, or on any error: rdata = '0.
- rdata returns to '0 when resp is NOTRDY.

Simultaneous events and hazards:
- A new request may be accepted in T+1 while its predecessor responds. Throughput is 1 access/cycle.
- Read in T+1 of the row written in T returns the new data, with byte-merge honoured (write-first, via bypass or commit ordering).
- Reset asserted mid-access: the pending response is dropped, resp goes NOTRDY immediately, and the write in flight is undefined.

Optional Feature:
- Macro: SCR1_VEC_TCM_INIT_EN.
- Defined:
  - After rst_n deasserts, an FSM INIT → RUN sweeps a row counter 0..DEPTH-1, writing '0 to all banks, one row per cycle.
  - req_ack = 0 and resp = NOTRDY throughout INIT.
  - RUN is entered after the row DEPTH-1 write, so the first req_ack = 1 comes DEPTH cycles after reset release.
  - Reset during INIT restarts the sweep at row 0.
- Undefined:
  - No FSM. req_ack = 1 from the first cycle after reset release; contents are X until written.

Test Plan:
- WORD write addr 0x00010000, wdata lane i = 0xA0000000+i, then RD same addr → T+1 resp RDY_OK, rdata lane i = 0xA0000000+i.
- BYTE write 0x00010002, lane i = 0x00550000, over a row of 0xFFFFFFFF, then RD → rdata lanes = 0xFF55FFFF. HWORD at 0x00010001 → RDY_ER and the row is unchanged.
- Back-to-back: WR row 3 in cycle T, RD row 3 in T+1, RD row 4 in T+2 → req_ack held 1, resp RDY_OK in T+1, T+2 and T+3, row-3 read shows new data.
- Out of range: RD at BASE + DEPTH*LANE*4, RD at BASE-4, RD with lane_off=1, cmd=ERROR → each gives RDY_ER, rdata='0.
- Reset asserted in the cycle after RD acceptance → resp NOTRDY and rdata '0 immediately; after release, the first request completes normally.
- With SCR1_VEC_TCM_INIT_EN: write pattern, assert reset, release → req_ack low exactly DEPTH cycles, then RD any row gives all lanes 0x00000000.
